// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encoding,
// the flag bundle and the per-beat control bits carried down the pipe.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
    } flags_t;

    // Control bits that travel alongside each beat.
    typedef struct packed {
        logic op;
        logic sat;
    } ctl_t;

endpackage

// File: rtl/adder_chunk.sv
// One pipeline stage: resolves the carry chain of chunk IDX, merges it into the
// running result word and forwards operands, carry and control to the next stage.
module adder_chunk
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    output logic             ready,
    output logic             valid_q,
    input  logic             ready_next,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  logic             carry,
    input  ctl_t             ctl,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] acc_q,
    output logic             carry_q,
    output logic             carry_msb_q,
    output ctl_t             ctl_q
);

    localparam int LO = IDX * CHUNK;
    localparam int HI = LO + CHUNK - 1;

    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] merged;

    always_comb begin
        part   = {1'b0, a[HI:LO]} + {1'b0, b[HI:LO]} + {{CHUNK{1'b0}}, carry};
        merged = acc;
        merged[HI:LO] = part[CHUNK-1:0];
    end

    // A stage may load when it is empty or its content moves on this cycle,
    // which lets bubbles collapse without a skid buffer.
    assign ready = !valid_q || ready_next;

    // NOTE: sequential state uses non-blocking assignments only; blocking here
    // would let a later stage see this cycle's value and skip a register.
    // NOTE: the data registers are reset as well because the last stage drives
    // the visible sum, which must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            carry_msb_q <= 1'b0;
            ctl_q       <= '0;
        end else if (ready) begin
            valid_q <= valid;
            if (valid) begin
                a_q         <= a;
                b_q         <= b;
                acc_q       <= merged;
                carry_q     <= part[CHUNK];
                // Carry into this chunk's top bit; only the last stage's copy
                // feeds the signed-overflow flag.
                carry_msb_q <= a[HI] ^ b[HI] ^ part[CHUNK-1];
                ctl_q       <= ctl;
            end
        end
    end

endmodule

// File: rtl/pipelined_adder_sub.sv
// Pipelined add/subtract unit with valid/ready handshake and carry/overflow/zero flags.
// Define ADDER_SAT_EN to add the sat input and signed saturation of the result.
module pipelined_adder_sub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
`ifdef ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("pipelined_adder_sub: WIDTH must be a multiple of STAGES");
    end

    logic [STAGES:0]  vld;
    logic [STAGES:0]  rdy;
    logic [WIDTH-1:0] a_p   [STAGES+1];
    logic [WIDTH-1:0] b_p   [STAGES+1];
    logic [WIDTH-1:0] acc_p [STAGES+1];
    logic             c_p   [STAGES+1];
    ctl_t             ctl_p [STAGES+1];
    logic             cmsb_p[STAGES];

    logic             sat_bit;
    logic [WIDTH-1:0] res;
    logic             ovf;
    flags_t           flags;

`ifdef ADDER_SAT_EN
    assign sat_bit = sat;
`else
    assign sat_bit = 1'b0;
`endif

    // Subtraction is a + ~b + ~cin, so cout = 1 means "no borrow".
    assign vld[0]   = in_valid;
    assign a_p[0]   = a;
    assign b_p[0]   = (op_sub == OP_ADD) ? b : ~b;
    assign acc_p[0] = '0;
    assign c_p[0]   = (op_sub == OP_SUB) ? ~cin : cin;
    assign ctl_p[0] = '{op: op_sub, sat: sat_bit};

    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_chunk #(
            .WIDTH(WIDTH),
            .CHUNK(CHUNK),
            .IDX  (k)
        ) u_chunk (
            .clk        (clk),
            .rst_n      (rst_n),
            .valid      (vld[k]),
            .ready      (rdy[k]),
            .valid_q    (vld[k+1]),
            .ready_next (rdy[k+1]),
            .a          (a_p[k]),
            .b          (b_p[k]),
            .acc        (acc_p[k]),
            .carry      (c_p[k]),
            .ctl        (ctl_p[k]),
            .a_q        (a_p[k+1]),
            .b_q        (b_p[k+1]),
            .acc_q      (acc_p[k+1]),
            .carry_q    (c_p[k+1]),
            .carry_msb_q(cmsb_p[k]),
            .ctl_q      (ctl_p[k+1])
        );
    end

    assign ovf = cmsb_p[STAGES-1] ^ c_p[STAGES];

    // NOTE: res gets its default before any conditional update so this block
    // can never infer a latch.
    always_comb begin
        res = acc_p[STAGES];
`ifdef ADDER_SAT_EN
        // On overflow the wrapped sign is the inverse of the true sign.
        if (ctl_p[STAGES].sat && ovf) begin
            res = acc_p[STAGES][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                         : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    // zero is qualified by out_valid so the idle/reset state reports 0.
    always_comb begin
        flags.cout     = c_p[STAGES];
        flags.overflow = ovf;
        flags.zero     = vld[STAGES] && (res == '0);
    end

    assign out_valid = vld[STAGES];
    assign sum       = res;
    assign cout      = flags.cout;
    assign overflow  = flags.overflow;
    assign zero      = flags.zero;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Scoreboard bench for pipelined_adder_sub: directed vectors push expectations,
// an independent monitor pops and compares every emitted result.
module tb_pipelined_adder_sub;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        o;
        logic        z;
        bit          lat_chk;
        int          acc_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    int   accepts   = 0;
    int   out_count = 0;

    pipelined_adder_sub #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .op_sub   (op_sub),
`ifdef ADDER_SAT_EN
        .sat      (sat),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o,
                                input logic z, input bit lat);
        exp_t e;
        e.sum = s; e.c = c; e.o = o; e.z = z; e.lat_chk = lat; e.acc_cyc = 0;
        return e;
    endfunction

    // Drives one beat from posedge+1 and returns at posedge+1 after its accept edge.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                        input logic top, input logic tsat, input exp_t e);
        bit done = 0;
        a = ta; b = tb; cin = tcin; op_sub = top; sat = tsat; in_valid = 1'b1;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc_cyc = cyc;
                sb.push_back(e);
                accepts++;
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("send_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 100 && sb.size() != 0; w++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                out_count++;
                check("output_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sum", sum, e.sum);
                    check("cout", cout, e.c);
                    check("overflow", overflow, e.o);
                    check("zero", zero, e.z);
                    if (e.lat_chk) check("latency", cyc - e.acc_cyc, STAGES);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, limit 500000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        op_sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 32'h0);
        check("rst_cout", cout, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_zero", zero, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single add with latency check.
        send(32'd5, 32'd9, 1'b0, 1'b0, 1'b0, mk(32'd14, 1'b0, 1'b0, 1'b0, 1));
        idle();
        drain();

        // Back-to-back beats, including a full carry ripple to zero.
        send(32'd16, 32'd32, 1'b0, 1'b0, 1'b0, mk(32'd48, 1'b0, 1'b0, 1'b0, 1));
        send(32'd128, 32'd64, 1'b0, 1'b0, 1'b0, mk(32'd192, 1'b0, 1'b0, 1'b0, 1));
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1, 1));
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1));
`ifdef ADDER_SAT_EN
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1));
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, mk(32'h8000_0000, 1'b1, 1'b1, 1'b0, 1));
`endif
        send(32'd1, 32'd1, 1'b1, 1'b0, 1'b0, mk(32'd3, 1'b0, 1'b0, 1'b0, 1));
        // Subtract: cout = 1 means no borrow.
        send(32'd5, 32'd9, 1'b0, 1'b1, 1'b0, mk(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1));
        send(32'd9, 32'd5, 1'b0, 1'b1, 1'b0, mk(32'd4, 1'b1, 1'b0, 1'b0, 1));
        send(32'd9, 32'd5, 1'b1, 1'b1, 1'b0, mk(32'd3, 1'b1, 1'b0, 1'b0, 1));
        send(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1));
        send(32'd5, 32'd5, 1'b0, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1, 1));
        idle();
        drain();

        // Backpressure: six beats offered against a 10-cycle output stall.
        base = accepts;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(32'h100 * (i + 1), i + 1, 1'b0, 1'b0, 1'b0,
                         mk(32'h101 * (i + 1), 1'b0, 1'b0, 1'b0, 0));
                idle();
            end
            begin
                out_ready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk); #1;
                    if (i == 5 || i == 9) begin
                        check("stall_out_valid", out_valid, 1'b1);
                        check("stall_sum_held", sum, 32'h101);
                    end
                end
                check("stall_in_ready", in_ready, 1'b0);
                check("stall_accepts", accepts - base, 4);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with beats in flight: everything is discarded.
        send(32'd11, 32'd22, 1'b0, 1'b0, 1'b0, mk(32'd33, 1'b0, 1'b0, 1'b0, 0));
        send(32'd44, 32'd55, 1'b0, 1'b0, 1'b0, mk(32'd99, 1'b0, 1'b0, 1'b0, 0));
        send(32'd66, 32'd77, 1'b0, 1'b0, 1'b0, mk(32'd143, 1'b0, 1'b0, 1'b0, 0));
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("inflight_rst_out_valid", out_valid, 1'b0);
        check("inflight_rst_sum", sum, 32'h0);
        check("inflight_rst_in_ready", in_ready, 1'b1);
        sb.delete();
        base = out_count;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("no_stale_output", out_count - base, 0);

        // Recovery after reset.
        send(32'd2, 32'd3, 1'b0, 1'b0, 1'b0, mk(32'd5, 1'b0, 1'b0, 1'b0, 1));
        idle();
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
